// File: rtl/seven_seg_scanner.sv
// Four-digit time-multiplexed driver for a common-anode 7-segment display.
// Scans snapshotted digit codes onto shared anode/segment lines with per-slot blanking.
`timescale 1ns/1ps

module seven_seg_scanner #(
  parameter int TICKS_PER_DIGIT = 100000,
  parameter int BLANK_TICKS     = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  output logic [3:0]  anodes,
  output logic [7:0]  segments,
  output logic        frame_tick
);

  localparam int                  CNT_W    = (TICKS_PER_DIGIT > 2) ? $clog2(TICKS_PER_DIGIT) : 1;
  localparam logic [CNT_W-1:0]    TERM_CNT = CNT_W'(TICKS_PER_DIGIT - 1);
  localparam logic [CNT_W:0]      BLANK_V  = (CNT_W + 1)'(BLANK_TICKS);

  // Active-low g..a pattern for a hex digit.
  function automatic logic [6:0] glyph(input logic [3:0] code);
    logic [6:0] g;
    case (code)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

  // Bit n set when digit n is a leading zero; digit 0 always stays visible.
  function automatic logic [3:0] lz_mask(input logic [15:0] d);
    logic [3:0] m;
    m[3] = (d[15:12] == 4'h0);
    m[2] = m[3] && (d[11:8] == 4'h0);
    m[1] = m[2] && (d[7:4] == 4'h0);
    m[0] = 1'b0;
    return m;
  endfunction

  logic [CNT_W-1:0] r_tick_cnt;
  logic [1:0]       r_idx;
  logic [15:0]      r_shadow_digits;
  logic [3:0]       r_shadow_dp;
  logic             r_wrap;

  logic             w_last;
  logic             w_in_blank;
  logic             w_lz_blank;
  logic [3:0]       w_digit;
  logic             w_dp;
  logic [3:0]       w_lz_mask;
  logic [3:0]       w_anodes_nxt;
  logic [7:0]       w_segments_nxt;
  logic             w_frame_tick_nxt;

  assign w_last = (r_tick_cnt == TERM_CNT);

  generate
    if (BLANK_TICKS == 0) begin : g_no_blank
      assign w_in_blank = 1'b0;
    end else begin : g_blank
      assign w_in_blank = ({1'b0, r_tick_cnt} < BLANK_V);
    end
  endgenerate

  // Slot counter, digit index and frame snapshot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tick_cnt      <= '0;
      r_idx           <= 2'd0;
      r_shadow_digits <= 16'h0000;
      r_shadow_dp     <= 4'h0;
      r_wrap          <= 1'b0;
    end else if (!enable) begin
      r_tick_cnt <= '0;
      r_idx      <= 2'd0;
      r_wrap     <= 1'b0;
    end else begin
      r_wrap <= w_last && (r_idx == 2'd3);
      if (w_last) begin
        r_tick_cnt <= '0;
        r_idx      <= r_idx + 2'd1;
        if (r_idx == 2'd3) begin
          r_shadow_digits <= digits;
          r_shadow_dp     <= dp_in;
        end
      end else begin
        r_tick_cnt <= r_tick_cnt + 1'b1;
      end
    end
  end

  assign w_digit    = r_shadow_digits[{r_idx, 2'b00} +: 4];
  assign w_dp       = r_shadow_dp[r_idx];
  assign w_lz_mask  = lz_mask(r_shadow_digits);
  assign w_lz_blank = blank_lz && w_lz_mask[r_idx];

  always_comb begin
    w_anodes_nxt     = 4'hF;
    w_segments_nxt   = 8'hFF;
    w_frame_tick_nxt = 1'b0;
    if (enable) begin
      w_frame_tick_nxt = r_wrap;
      if (!w_in_blank && !w_lz_blank) begin
        w_anodes_nxt   = ~(4'b0001 << r_idx);
        w_segments_nxt = {~w_dp, glyph(w_digit)};
      end
    end
  end

  // Output register stage: one clk behind the counter state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      anodes     <= 4'hF;
      segments   <= 8'hFF;
      frame_tick <= 1'b0;
    end else begin
      anodes     <= w_anodes_nxt;
      segments   <= w_segments_nxt;
      frame_tick <= w_frame_tick_nxt;
    end
  end

endmodule
